// File: rtl/bus_rr_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module      : bus_rr_arbiter_if
// Description : Start/done bus bundle between N masters, the arbiter and one slave.
// Revision    : 1.0 - initial release
// =============================================================================
interface bus_rr_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 27,
    parameter int DATA_WIDTH  = 32
);
    logic [NUM_MASTERS-1:0]            m_start;
    logic [NUM_MASTERS-1:0]            m_we;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data;
    logic [DATA_WIDTH-1:0]             m_q;
    logic [NUM_MASTERS-1:0]            m_done;
    logic [NUM_MASTERS-1:0]            m_err;
    logic                              s_start;
    logic                              s_we;
    logic [ADDR_WIDTH-1:0]             s_addr;
    logic [DATA_WIDTH-1:0]             s_data;
    logic [DATA_WIDTH-1:0]             s_q;
    logic                              s_done;

    // slave: the arbiter's view (it serves the masters); master: the surrounding system
    modport slave (
        input  m_start, m_we, m_addr, m_data, s_q, s_done,
        output m_q, m_done, m_err, s_start, s_we, s_addr, s_data
    );
    modport master (
        output m_start, m_we, m_addr, m_data, s_q, s_done,
        input  m_q, m_done, m_err, s_start, s_we, s_addr, s_data
    );
endinterface
`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : bus_rr_arbiter
// Description : N-master round-robin arbiter for the start/done bus with timeout.
// Revision    : 1.0 - initial release
// =============================================================================
module bus_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 27,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic         i_clk,
    input  wire logic         i_reset,
    bus_rr_arbiter_if.slave   bus
);
    localparam int c_GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int c_CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_TO_LAST   = c_CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [c_GW-1:0] c_LAST_INIT = c_GW'(NUM_MASTERS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]             r_state_q,      w_state_d;
    logic [c_GW-1:0]        r_last_grant_q, w_last_grant_d;
    logic [c_CW-1:0]        r_cnt_q,        w_cnt_d;
    logic                   r_s_start_q,    w_s_start_d;
    logic                   r_s_we_q,       w_s_we_d;
    logic [ADDR_WIDTH-1:0]  r_s_addr_q,     w_s_addr_d;
    logic [DATA_WIDTH-1:0]  r_s_data_q,     w_s_data_d;
    logic [DATA_WIDTH-1:0]  r_rdata_q,      w_rdata_d;
    logic [NUM_MASTERS-1:0] r_done_q,       w_done_d;
    logic [NUM_MASTERS-1:0] r_err_q,        w_err_d;

    logic                   w_req_found;
    logic [c_GW-1:0]        w_grant;
    logic                   w_sel_we;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic [NUM_MASTERS-1:0] w_grant_onehot;

    // Scan starts one past the previous winner so every holder of m_start is served in turn.
    always_comb begin : p_grant
        logic [c_GW-1:0] v_idx;
        v_idx       = '0;
        w_req_found = 1'b0;
        w_grant     = r_last_grant_q;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            v_idx = c_GW'((int'(r_last_grant_q) + k) % NUM_MASTERS);
            if (!w_req_found && bus.m_start[v_idx]) begin
                w_req_found = 1'b1;
                w_grant     = v_idx;
            end
        end
        w_sel_we   = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_grant == c_GW'(i)) begin
                w_sel_we   = bus.m_we[i];
                w_sel_addr = bus.m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = bus.m_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_grant_onehot = NUM_MASTERS'(1) << r_last_grant_q;

    always_comb begin : p_next
        w_state_d      = r_state_q;
        w_last_grant_d = r_last_grant_q;
        w_cnt_d        = r_cnt_q;
        w_s_start_d    = r_s_start_q;
        w_s_we_d       = r_s_we_q;
        w_s_addr_d     = r_s_addr_q;
        w_s_data_d     = r_s_data_q;
        w_rdata_d      = r_rdata_q;
        w_done_d       = '0;
        w_err_d        = '0;
        case (r_state_q)
            c_ST_IDLE: begin
                if (w_req_found) begin
                    w_s_start_d    = 1'b1;
                    w_s_we_d       = w_sel_we;
                    w_s_addr_d     = w_sel_addr;
                    w_s_data_d     = w_sel_data;
                    w_last_grant_d = w_grant;
                    w_cnt_d        = '0;
                    w_state_d      = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (bus.s_done) begin
                    w_s_start_d = 1'b0;
                    w_rdata_d   = bus.s_q;
                    w_done_d    = w_grant_onehot;
                    w_state_d   = c_ST_RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (r_cnt_q == c_TO_LAST)) begin
                    w_s_start_d = 1'b0;
                    w_rdata_d   = '0;
                    w_done_d    = w_grant_onehot;
                    w_err_d     = w_grant_onehot;
                    w_state_d   = c_ST_RESP;
                end else begin
                    w_cnt_d = r_cnt_q + c_CW'(1);
                end
            end
            c_ST_RESP: w_state_d = c_ST_IDLE;
            default:   w_state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state_q      <= c_ST_IDLE;
            r_last_grant_q <= c_LAST_INIT;
            r_cnt_q        <= '0;
            r_s_start_q    <= 1'b0;
            r_s_we_q       <= 1'b0;
            r_s_addr_q     <= '0;
            r_s_data_q     <= '0;
            r_rdata_q      <= '0;
            r_done_q       <= '0;
            r_err_q        <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_last_grant_q <= w_last_grant_d;
            r_cnt_q        <= w_cnt_d;
            r_s_start_q    <= w_s_start_d;
            r_s_we_q       <= w_s_we_d;
            r_s_addr_q     <= w_s_addr_d;
            r_s_data_q     <= w_s_data_d;
            r_rdata_q      <= w_rdata_d;
            r_done_q       <= w_done_d;
            r_err_q        <= w_err_d;
        end
    end

    // Masking with s_done keeps the slave from taking the request twice in its done cycle.
    assign bus.s_start = r_s_start_q & ~bus.s_done;
    assign bus.s_we    = r_s_we_q & r_s_start_q;
    assign bus.s_addr  = r_s_addr_q;
    assign bus.s_data  = r_s_data_q;
    assign bus.m_q     = r_rdata_q;
    assign bus.m_done  = r_done_q;
    assign bus.m_err   = r_err_q;
endmodule
`default_nettype wire

// File: tb/tb_bus_rr_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : tb_bus_rr_arbiter
// Description : Directed scoreboard bench for bus_rr_arbiter (2- and 3-master builds).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_bus_rr_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_rr_arbiter_if #(.NUM_MASTERS(2), .ADDR_WIDTH(27), .DATA_WIDTH(32)) a ();
    bus_rr_arbiter_if #(.NUM_MASTERS(3), .ADDR_WIDTH(27), .DATA_WIDTH(32)) b ();

    bus_rr_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(27), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8))
        dut_a (.i_clk(clk), .i_reset(rst), .bus(a.slave));
    bus_rr_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(27), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8))
        dut_b (.i_clk(clk), .i_reset(rst), .bus(b.slave));

    typedef struct {
        int          master;
        logic [31:0] q;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          sl_lat = 0;
    logic [31:0] sl_rdata = 32'h1000;
    int          start_cnt = 0;
    int          s0;

    // Slave model: responds in the sl_lat-th cycle of a visible s_start, never when sl_lat is 0.
    initial begin
        int cnt;
        cnt = 0;
        a.s_done = 1'b0;
        a.s_q    = '0;
        forever begin
            @(negedge clk);
            if (a.s_done) begin
                a.s_done = 1'b0;
                cnt = 0;
            end else if (a.s_start === 1'b1) begin
                cnt++;
                if (sl_lat != 0 && cnt == sl_lat) begin
                    a.s_done = 1'b1;
                    a.s_q    = sl_rdata + 32'(a.s_addr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (a.s_start === 1'b1) start_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int m, input logic [31:0] q, input logic err);
        exp_t e;
        e.master = m;
        e.q      = q;
        e.err    = err;
        sb.push_back(e);
    endtask

    task automatic a_wait(input string tag, input int exp_ticks, input bit keep);
        int          n;
        bit          got;
        exp_t        e;
        logic [1:0]  mask;
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            tick();
            n++;
            if (a.m_done !== 2'b00) got = 1'b1;
        end
        chk({tag, "_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, "_lat"}, 64'(n), 64'(exp_ticks));
            if (sb.size() != 0) e = sb.pop_front();
            else begin
                e.master = -1;
                e.q      = '0;
                e.err    = 1'b0;
            end
            mask = (e.master >= 0) ? (2'b01 << e.master) : 2'b00;
            chk({tag, "_done"}, 64'(a.m_done), 64'(mask));
            chk({tag, "_err"},  64'(a.m_err), 64'(e.err ? mask : 2'b00));
            chk({tag, "_q"},    64'(a.m_q), 64'(e.q));
            if (!keep) a.m_start = '0;
            tick();
            chk({tag, "_pulse"}, 64'(a.m_done), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        a.m_start = '0; a.m_we = '0; a.m_addr = '0; a.m_data = '0;
        b.m_start = '0; b.m_we = '0; b.m_addr = '0; b.m_data = '0;
        b.s_done  = 1'b0; b.s_q = '0;
        repeat (3) tick();
        chk("rst_done",  64'(a.m_done), 64'd0);
        chk("rst_err",   64'(a.m_err), 64'd0);
        chk("rst_q",     64'(a.m_q), 64'd0);
        chk("rst_start", 64'(a.s_start), 64'd0);
        chk("rst_we",    64'(a.s_we), 64'd0);
        chk("rst_addr",  64'(a.s_addr), 64'd0);
        chk("rst_data",  64'(a.s_data), 64'd0);
        chk("rst_b_done", 64'(b.m_done), 64'd0);
        rst = 1'b0;
        tick();

        // Single write, slave answers in the 4th s_start cycle
        sl_lat = 4;
        a.m_we[0] = 1'b1; a.m_addr[26:0] = 27'd4; a.m_data[31:0] = 32'd37;
        push(0, 32'h1004, 1'b0);
        s0 = start_cnt;
        a.m_start[0] = 1'b1;
        tick();
        chk("wr_start", 64'(a.s_start), 64'd1);
        chk("wr_addr",  64'(a.s_addr), 64'd4);
        chk("wr_data",  64'(a.s_data), 64'd37);
        chk("wr_we",    64'(a.s_we), 64'd1);
        a.m_addr[26:0] = 27'd9; a.m_data[31:0] = 32'd99;
        tick();
        chk("wr_addr_hold", 64'(a.s_addr), 64'd4);
        chk("wr_data_hold", 64'(a.s_data), 64'd37);
        a_wait("wr", 3, 1'b0);
        chk("wr_start_cycles", 64'(start_cnt - s0), 64'd3);
        chk("wr_we_idle", 64'(a.s_we), 64'd0);

        // Read on master 1, one-cycle slave latency
        sl_lat = 2; sl_rdata = 32'hDEADBEEC;
        a.m_we[1] = 1'b0; a.m_addr[53:27] = 27'd3;
        push(1, 32'hDEADBEEF, 1'b0);
        s0 = start_cnt;
        a.m_start[1] = 1'b1;
        tick();
        chk("rd_we",   64'(a.s_we), 64'd0);
        chk("rd_addr", 64'(a.s_addr), 64'd3);
        a_wait("rd", 2, 1'b0);
        chk("rd_start_cycles", 64'(start_cnt - s0), 64'd1);

        // Fairness: both masters hold requests for six transactions
        sl_rdata = 32'h1000;
        a.m_addr[26:0] = 27'd16; a.m_addr[53:27] = 27'd32;
        for (int i = 0; i < 6; i++) push(i % 2, (i % 2 == 0) ? 32'h1010 : 32'h1020, 1'b0);
        a.m_start = 2'b11;
        for (int i = 0; i < 6; i++) a_wait("rr", 3, (i < 5));

        // Timeout: slave silent
        sl_lat = 0;
        a.m_addr[26:0] = 27'd8;
        push(0, 32'h0, 1'b1);
        s0 = start_cnt;
        a.m_start[0] = 1'b1;
        a_wait("to", 9, 1'b0);
        chk("to_start_cycles", 64'(start_cnt - s0), 64'd8);
        sl_lat = 2;
        push(1, 32'h1020, 1'b0);
        a.m_start[1] = 1'b1;
        a_wait("post_to", 3, 1'b0);

        // Reset two cycles into a transaction
        sl_lat = 0;
        a.m_start[0] = 1'b1;
        tick();
        tick();
        chk("mid_start", 64'(a.s_start), 64'd1);
        rst = 1'b1;
        a.m_start = '0;
        tick();
        chk("mrst_done",  64'(a.m_done), 64'd0);
        chk("mrst_err",   64'(a.m_err), 64'd0);
        chk("mrst_q",     64'(a.m_q), 64'd0);
        chk("mrst_start", 64'(a.s_start), 64'd0);
        chk("mrst_we",    64'(a.s_we), 64'd0);
        chk("mrst_addr",  64'(a.s_addr), 64'd0);
        chk("mrst_data",  64'(a.s_data), 64'd0);
        rst = 1'b0;
        sl_lat = 2;
        push(0, 32'h1008, 1'b0);
        push(1, 32'h1020, 1'b0);
        a.m_start = 2'b11;
        a_wait("rst_g0", 3, 1'b1);
        a_wait("rst_g1", 3, 1'b0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // Three masters, only m2 requests, slave done in the first s_start cycle
        b.m_we[2] = 1'b1; b.m_addr[80:54] = 27'd5; b.m_data[95:64] = 32'hABCD;
        b.m_start = 3'b100;
        tick();
        chk("b_start", 64'(b.s_start), 64'd1);
        chk("b_addr",  64'(b.s_addr), 64'd5);
        chk("b_data",  64'(b.s_data), 64'hABCD);
        chk("b_we",    64'(b.s_we), 64'd1);
        b.s_done = 1'b1; b.s_q = 32'h55AA;
        #1;
        chk("b_start_masked", 64'(b.s_start), 64'd0);
        tick();
        b.s_done = 1'b0;
        chk("b_done", 64'(b.m_done), 64'h4);
        chk("b_err",  64'(b.m_err), 64'd0);
        chk("b_q",    64'(b.m_q), 64'h55AA);
        b.m_start = '0;
        tick();
        chk("b_done_clr",  64'(b.m_done), 64'd0);
        chk("b_start_idle", 64'(b.s_start), 64'd0);
        tick();
        chk("b_no_regrant", 64'(b.s_start), 64'd0);
        chk("b_we_idle",    64'(b.s_we), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
